dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester round-robin arbiter and access sequencer in front of the single-port, byte-addressable, big-endian data_memory.
- Requester 0 is the core load/store path; requester 1 is the debug/DMA loader.
- Issues word, halfword and byte accesses. Sub-word stores are done as read-modify-write, because data_memory always writes 4 bytes.
- Flags misaligned and out-of-range accesses with err and never touches memory for them.

Parameters:
- MEM_BYTES, 1024, size of data_memory in bytes; an access is legal only if addr + nbytes <= MEM_BYTES.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  2  per-requester request, bit i = requester i; held high until ack[i].
- we  in  2  per-requester write enable (1 = store).
- size  in  4  per-requester size, [2i+1:2i]: 00 byte, 01 half, 10 word, 11 illegal (err).
- addr  in  64  per-requester byte address, [32i+31:32i].
- wdata  in  64  per-requester store data, right-justified (byte in [7:0], half in [15:0]).
- ack  out  2  one-cycle completion pulse for the granted requester.
- err  out  1  valid with ack; 1 = access rejected.
- rdata  out  32  load data, valid with ack; zero-extended, right-justified.
- mem_address  out  32  to data_memory address.
- mem_write  out  1  to data_memory memwrite.
- mem_write_data  out  32  to data_memory write_data.
- mem_read_data  in  32  from data_memory read_data (combinational read).

Behaviour:
- Reset values:
  - state=IDLE; ack=0, err=0, rdata=0.
  - mem_write=0 (forced low combinationally while reset=1, so no write lands on a reset edge).
  - mem_address=0, mem_write_data=0.
  - last_grant=1, so requester 0 wins the first tie.
- FSM: IDLE, ACCESS, MERGE, RESP.
- IDLE:
  - If no req, stay.
  - If one req, grant it. If both req, grant the one != last_grant.
  - Latch we, size, addr and wdata of the winner, plus the winner index.
  - If the latched access is illegal, go to RESP with err pending; otherwise go to ACCESS.
  - Illegal means: size=11; half with addr[0]!=0; word with addr[1:0]!=0; or addr + nbytes > MEM_BYTES.
- ACCESS:
  - mem_address = {addr[31:2],2'b00}.
  - Load: capture the lane from mem_read_data. Byte lane k = addr[1:0] is mem_read_data[31-8k -: 8]. Half lane is [31:16] when addr[1]=0, else [15:0]. Zero-extend into rdata. Go to RESP.
  - Word store: mem_write=1, mem_write_data=wdata. Go to RESP.
  - Sub-word store: capture mem_read_data into a merge register. Go to MERGE.
- MERGE:
  - mem_address unchanged, mem_write=1.
  - mem_write_data = captured word with only the addressed lane(s) replaced by wdata[7:0] or wdata[15:0]. Same lane mapping as for loads.
  - Go to RESP.
- RESP:
  - ack[winner]=1 for exactly this cycle; err and rdata valid this cycle. rdata=0 on stores and on err.
  - last_grant <= winner. Next state is IDLE.
- Latency, counted from the IDLE cycle in which req is sampled:
  - load / word store: ack 2 cycles later.
  - sub-word store: ack 3 cycles later.
  - illegal access: ack 1 cycle later.
- Request rules:
  - req is only sampled in IDLE. Changes to a granted requester's fields after the latch are ignored.
  - A requester drops req on the cycle after ack. If req is still high in IDLE, it is a new request.
  - The losing requester waits with req held. Round-robin bounds its wait to one access.
- Only ACCESS (word store) and MERGE drive mem_write=1. Every other state drives mem_write=0 and mem_write_data=0.
- Reset mid-operation: the FSM returns to IDLE and the in-flight request is dropped without ack.
  - If reset arrives in ACCESS/MERGE, that cycle's write is suppressed.
  - The requester must reissue the request.

Test Plan:
- Load word: memory bytes 0x10..0x13 = 11 22 33 44; req0 load word @0x10 -> ack[0] 2 cycles after sample, rdata=0x11223344, err=0.
- Byte store RMW: same memory; req0 store byte 0xAB @0x12 -> exactly one write (MERGE) of 0x1122AB44 to 0x10; ack 3 cycles after sample; reload byte @0x12 returns 0x000000AB.
- Arbitration: req=2'b11 held continuously, word loads -> ack sequence 0,1,0,1; no ack gap longer than one access.
- Errors: half @0x11 -> ack 1 cycle after sample, err=1, mem_write never 1. Word @0x3FD with MEM_BYTES=1024 -> err=1. size=11 -> err=1.
- Reset mid-RMW: assert reset during MERGE of store byte 0xFF @0x10 -> no ack, memory unchanged at 0x11223344, state=IDLE, next tie goes to requester 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-requester round-robin arbiter and access sequencer in front
//            of a single-port, byte-addressable, big-endian data memory.
//            Issues byte/half/word accesses; sub-word stores are performed as
//            read-modify-write because the memory always writes 4 bytes.
//            Misaligned or out-of-range accesses are rejected with err and
//            never reach memory.
// Ports    : clk, reset            clock, synchronous active-high reset
//            req/we [1:0]          per-requester request / store enable
//            size [3:0]            per-requester size (00 B, 01 H, 10 W, 11 bad)
//            addr/wdata [63:0]     per-requester address / right-justified data
//            ack [1:0], err, rdata completion pulse, reject flag, load data
//            mem_*                 data_memory address/write/data/read-data
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [3:0]  size,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [1:0]  ack,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_MERGE  = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        win_q, win_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;

  // Winner selection and legality of the winner's access
  logic        w_win;
  logic [1:0]  w_size;
  logic [31:0] w_addr;
  logic [32:0] w_end;
  logic        w_illegal;

  always_comb begin
    // A lone requester wins; on a tie the one that did not win last time wins.
    w_win = 1'b1;
    if (req[0]) w_win = req[1] & ~last_grant_q;
    w_size = w_win ? size[3:2] : size[1:0];
    w_addr = w_win ? addr[63:32] : addr[31:0];
    case (w_size)
      2'b00:   w_end = {1'b0, w_addr} + 33'd1;
      2'b01:   w_end = {1'b0, w_addr} + 33'd2;
      default: w_end = {1'b0, w_addr} + 33'd4;
    endcase
    w_illegal = (w_size == 2'b11)
             || ((w_size == 2'b01) && w_addr[0])
             || ((w_size == 2'b10) && (w_addr[1:0] != 2'b00))
             || (w_end > 33'(MEM_BYTES));
  end

  // Lane extraction (loads) and lane replacement (RMW). Lane 0 is the most
  // significant byte because the memory is big-endian.
  logic [31:0] w_lane_rd;
  logic [31:0] w_merged;

  always_comb begin
    w_lane_rd = mem_read_data;
    w_merged  = merge_q;
    case (size_q)
      2'b00: begin
        case (addr_q[1:0])
          2'd0: begin w_lane_rd = {24'd0, mem_read_data[31:24]}; w_merged[31:24] = wdata_q[7:0]; end
          2'd1: begin w_lane_rd = {24'd0, mem_read_data[23:16]}; w_merged[23:16] = wdata_q[7:0]; end
          2'd2: begin w_lane_rd = {24'd0, mem_read_data[15:8]};  w_merged[15:8]  = wdata_q[7:0]; end
          default: begin w_lane_rd = {24'd0, mem_read_data[7:0]}; w_merged[7:0] = wdata_q[7:0]; end
        endcase
      end
      2'b01: begin
        if (addr_q[1]) begin
          w_lane_rd      = {16'd0, mem_read_data[15:0]};
          w_merged[15:0] = wdata_q[15:0];
        end else begin
          w_lane_rd       = {16'd0, mem_read_data[31:16]};
          w_merged[31:16] = wdata_q[15:0];
        end
      end
      default: begin
        w_lane_rd = mem_read_data;
      end
    endcase
  end

  // Next-state and output logic
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    win_d          = win_q;
    we_d           = we_q;
    err_d          = err_q;
    size_d         = size_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    merge_d        = merge_q;
    rdata_d        = rdata_q;
    ack            = 2'b00;
    err            = 1'b0;
    rdata          = 32'd0;
    mem_address    = 32'd0;
    mem_write      = 1'b0;
    mem_write_data = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          win_d   = w_win;
          we_d    = w_win ? we[1] : we[0];
          size_d  = w_size;
          addr_d  = w_addr;
          wdata_d = w_win ? wdata[63:32] : wdata[31:0];
          err_d   = w_illegal;
          rdata_d = 32'd0;
          state_d = w_illegal ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_address = {addr_q[31:2], 2'b00};
        if (!we_q) begin
          rdata_d = w_lane_rd;
          state_d = S_RESP;
        end else if (size_q == 2'b10) begin
          mem_write      = 1'b1;
          mem_write_data = wdata_q;
          state_d        = S_RESP;
        end else begin
          merge_d = mem_read_data;
          state_d = S_MERGE;
        end
      end
      S_MERGE: begin
        mem_address    = {addr_q[31:2], 2'b00};
        mem_write      = 1'b1;
        mem_write_data = w_merged;
        state_d        = S_RESP;
      end
      S_RESP: begin
        ack          = win_q ? 2'b10 : 2'b01;
        err          = err_q;
        rdata        = rdata_q;
        last_grant_d = win_q;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Reset is synchronous, so the FSM may still sit in ACCESS/MERGE during
    // the reset cycle; block the write so nothing lands on the reset edge.
    if (reset) begin
      mem_write      = 1'b0;
      mem_write_data = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      win_q        <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      size_q       <= 2'b00;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      merge_q      <= 32'd0;
      rdata_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      win_q        <= win_d;
      we_q         <= we_d;
      err_q        <= err_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      merge_q      <= merge_d;
      rdata_q      <= rdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter. Owns a byte-array data
//            memory, drives both requesters, and compares the DUT on every
//            cycle against a transaction-level model of the arbiter built
//            from a big-endian byte array and the access latencies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, we, ack;
  logic [3:0]  size;
  logic [63:0] addr, wdata;
  logic        err, mem_write;
  logic [31:0] rdata, mem_address, mem_write_data, mem_read_data;

  logic        rq [2];
  logic        wq [2];
  logic [1:0]  sz [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];

  assign req   = {rq[1], rq[0]};
  assign we    = {wq[1], wq[0]};
  assign size  = {sz[1], sz[0]};
  assign addr  = {ad[1], ad[0]};
  assign wdata = {wd[1], wd[0]};

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_BYTES(1024)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .addr(addr),
    .wdata(wdata), .ack(ack), .err(err), .rdata(rdata),
    .mem_address(mem_address), .mem_write(mem_write),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int wr_count = 0;
  logic checking = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- data memory seen by the DUT ----------------
  logic [7:0]  dut_mem [1024];
  logic        bd_fill = 1'b0;
  logic        bd_valid = 1'b0;
  logic [31:0] bd_addr = 32'd0;
  logic [31:0] bd_data = 32'd0;
  logic [9:0]  rd_base;

  assign rd_base = {mem_address[9:2], 2'b00};
  assign mem_read_data = {dut_mem[rd_base], dut_mem[rd_base + 10'd1],
                          dut_mem[rd_base + 10'd2], dut_mem[rd_base + 10'd3]};

  always @(posedge clk) begin
    if (bd_fill)
      for (int j = 0; j < 1024; j++) dut_mem[j] <= 8'(j * 7 + 3);
    if (bd_valid)
      for (int b = 0; b < 4; b++) dut_mem[bd_addr[9:0] + 10'(b)] <= 8'(bd_data >> (8 * (3 - b)));
    if (mem_write) begin
      for (int b = 0; b < 4; b++) dut_mem[rd_base + 10'(b)] <= 8'(mem_write_data >> (8 * (3 - b)));
      wr_count <= wr_count + 1;
    end
  end

  function automatic logic [31:0] dut_word(input logic [31:0] a);
    logic [9:0] x;
    x = {a[9:2], 2'b00};
    return {dut_mem[x], dut_mem[x + 10'd1], dut_mem[x + 10'd2], dut_mem[x + 10'd3]};
  endfunction

  // ---------------- transaction-level reference model ----------------
  logic [7:0]  ref_mem [1024];
  logic        pend = 1'b0;
  logic        last = 1'b1;
  logic        p_win, p_we, p_bad;
  logic [1:0]  p_sz;
  logic [31:0] p_addr, p_wdata;
  int          p_n, p_s, p_ack;
  int          nfree = 0;

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int x;
    x = int'({a[9:2], 2'b00});
    return {ref_mem[x], ref_mem[x + 1], ref_mem[x + 2], ref_mem[x + 3]};
  endfunction

  always @(negedge clk) begin
    logic [1:0]  exp_ack;
    logic        exp_err, exp_wr;
    logic [31:0] exp_rd;
    int          lat;
    cyc++;
    if (checking) begin
      exp_ack = 2'b00;
      exp_err = 1'b0;
      exp_rd  = 32'd0;
      exp_wr  = 1'b0;
      if (pend && cyc == p_ack) begin
        exp_ack = p_win ? 2'b10 : 2'b01;
        exp_err = p_bad;
        if (!p_bad && !p_we)
          for (int b = 0; b < p_n; b++) exp_rd = (exp_rd << 8) | {24'd0, ref_mem[int'(p_addr) + b]};
        if (!p_bad && p_we)
          for (int b = 0; b < p_n; b++) ref_mem[int'(p_addr) + b] = 8'(p_wdata >> (8 * (p_n - 1 - b)));
      end
      if (pend && !p_bad && p_we && !reset && cyc == p_s + ((p_n == 4) ? 1 : 2)) exp_wr = 1'b1;

      check("ack", {30'd0, ack}, {30'd0, exp_ack});
      if (exp_ack != 2'b00) begin
        check("err", {31'd0, err}, {31'd0, exp_err});
        check("rdata", rdata, exp_rd);
        if (!p_bad && p_we) check("store_word", dut_word(p_addr), ref_word(p_addr));
      end
      check("mem_write", {31'd0, mem_write}, {31'd0, exp_wr});
      if (exp_wr) check("mem_address", mem_address, {p_addr[31:2], 2'b00});
      else        check("mem_wdata_idle", mem_write_data, 32'd0);

      if (reset) begin
        pend  = 1'b0;
        last  = 1'b1;
        nfree = cyc + 1;
      end else begin
        if (pend && cyc == p_ack) begin
          pend = 1'b0;
          last = p_win;
        end
        if (!pend && cyc >= nfree && (rq[0] || rq[1])) begin
          p_win   = (rq[0] && rq[1]) ? ~last : rq[1];
          p_we    = wq[p_win];
          p_sz    = sz[p_win];
          p_addr  = ad[p_win];
          p_wdata = wd[p_win];
          p_n     = (p_sz == 2'b00) ? 1 : (p_sz == 2'b01) ? 2 : 4;
          p_bad   = (p_sz == 2'b11) || ((p_addr % 32'(p_n)) != 0)
                 || (longint'(p_addr) + longint'(p_n) > 64'd1024);
          lat     = p_bad ? 1 : (p_we && p_n < 4) ? 3 : 2;
          p_s     = cyc;
          p_ack   = cyc + lat;
          nfree   = p_ack + 1;
          pend    = 1'b1;
        end
      end
    end
    if (bd_fill)
      for (int j = 0; j < 1024; j++) ref_mem[j] = 8'(j * 7 + 3);
    if (bd_valid)
      for (int b = 0; b < 4; b++) ref_mem[int'(bd_addr[9:0]) + b] = 8'(bd_data >> (8 * (3 - b)));
  end

  // ---------------- stimulus helpers (called at posedge + 1) ----------------
  task automatic bd_word(input logic [31:0] a, input logic [31:0] d);
    bd_addr = a; bd_data = d; bd_valid = 1'b1;
    @(posedge clk); #1;
    bd_valid = 1'b0;
  endtask

  task automatic issue(input int i, input logic w, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic e, output logic [31:0] r, output int lat);
    rq[i] = 1'b1; wq[i] = w; sz[i] = s; ad[i] = a; wd[i] = d;
    lat = 0;
    while (ack[i] !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    e = err;
    r = rdata;
    if (ack[i] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: requester %0d got no ack after %0d cycles, required ack", i, lat);
    end
    @(posedge clk); #1;
    rq[i] = 1'b0;
  endtask

  task automatic rand_driver(input int i, input int n);
    logic        e;
    logic [31:0] r, a;
    logic [1:0]  s;
    int          lat, sel;
    for (int t = 0; t < n; t++) begin
      sel = int'($urandom_range(0, 9));
      s   = (sel == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a   = 32'($urandom_range(0, 1023));
      if (sel < 7) begin
        if (s == 2'b01) a[0] = 1'b0;
        if (s == 2'b10) a[1:0] = 2'b00;
      end
      if (sel == 9) a = 32'($urandom_range(1018, 1030));
      issue(i, 1'($urandom_range(0, 1)), s, a, $urandom, e, r, lat);
      check("rr_wait_bound", {31'd0, (lat <= 7)}, 32'd1);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  // ---------------- main sequence ----------------
  logic        e0, e1;
  logic [31:0] r0, r1;
  int          l0, l1, wc0;
  int          ord [$];
  int          acyc [$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time, required finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rq[i] = 1'b0; wq[i] = 1'b0; sz[i] = 2'b00; ad[i] = 32'd0; wd[i] = 32'd0;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checking = 1'b1;
    bd_fill  = 1'b1;
    check("rst_ack", {30'd0, ack}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_mem_wdata", mem_write_data, 32'd0);
    @(posedge clk); #1;
    bd_fill = 1'b0;
    reset   = 1'b0;

    // Word load
    bd_word(32'h10, 32'h11223344);
    issue(0, 1'b0, 2'b10, 32'h10, 32'd0, e0, r0, l0);
    check("ld_word_lat", l0, 32'd2);
    check("ld_word_err", {31'd0, e0}, 32'd0);
    check("ld_word_data", r0, 32'h11223344);

    // Byte store via RMW, then reload
    wc0 = wr_count;
    issue(0, 1'b1, 2'b00, 32'h12, 32'h000000AB, e0, r0, l0);
    check("st_byte_lat", l0, 32'd3);
    check("st_byte_writes", wr_count - wc0, 32'd1);
    check("st_byte_mem", dut_word(32'h10), 32'h1122AB44);
    issue(0, 1'b0, 2'b00, 32'h12, 32'd0, e0, r0, l0);
    check("ld_byte_data", r0, 32'h000000AB);
    issue(1, 1'b0, 2'b01, 32'h12, 32'd0, e0, r0, l0);
    check("ld_half_lo", r0, 32'h0000AB44);

    // Rejected accesses and range boundary
    wc0 = wr_count;
    issue(0, 1'b1, 2'b01, 32'h11, 32'h1234, e0, r0, l0);
    check("err_half_lat", l0, 32'd1);
    check("err_half_err", {31'd0, e0}, 32'd1);
    issue(0, 1'b0, 2'b10, 32'h3FD, 32'd0, e0, r0, l0);
    check("err_range_err", {31'd0, e0}, 32'd1);
    issue(1, 1'b1, 2'b11, 32'h20, 32'hFFFF_FFFF, e0, r0, l0);
    check("err_size_err", {31'd0, e0}, 32'd1);
    check("err_no_writes", wr_count - wc0, 32'd0);
    issue(0, 1'b0, 2'b10, 32'h3FC, 32'd0, e0, r0, l0);
    check("top_word_err", {31'd0, e0}, 32'd0);
    check("top_word_data", r0, 32'hE7EEF5FC);
    issue(0, 1'b1, 2'b00, 32'h3FF, 32'h5A, e0, r0, l0);
    check("top_byte_err", {31'd0, e0}, 32'd0);
    check("top_byte_mem", dut_word(32'h3FC), 32'hE7EEF55A);

    // Reset in the middle of a read-modify-write
    bd_word(32'h10, 32'h11223344);
    wc0 = wr_count;
    rq[0] = 1'b1; wq[0] = 1'b1; sz[0] = 2'b00; ad[0] = 32'h10; wd[0] = 32'hFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rmw_merge_write", {31'd0, mem_write}, 32'd1);
    reset = 1'b1;
    rq[0] = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_ack", {30'd0, ack}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_mem", dut_word(32'h10), 32'h11223344);
    check("rst_mid_writes", wr_count - wc0, 32'd0);

    // Both requesters held continuously: strict alternation starting at 0
    fork
      begin
        for (int k = 0; k < 2; k++) begin
          issue(0, 1'b0, 2'b10, 32'h10, 32'd0, e0, r0, l0);
          ord.push_back(0); acyc.push_back(cyc);
        end
      end
      begin
        for (int k = 0; k < 2; k++) begin
          issue(1, 1'b0, 2'b10, 32'h3FC, 32'd0, e1, r1, l1);
          ord.push_back(1); acyc.push_back(cyc);
        end
      end
    join
    check("arb_count", ord.size(), 32'd4);
    if (ord.size() == 4) begin
      check("arb_0", ord[0], 32'd0);
      check("arb_1", ord[1], 32'd1);
      check("arb_2", ord[2], 32'd0);
      check("arb_3", ord[3], 32'd1);
      for (int k = 1; k < 4; k++) check("arb_gap", acyc[k] - acyc[k-1], 32'd3);
    end

    // Randomized traffic from both requesters
    fork
      rand_driver(0, 60);
      rand_driver(1, 60);
    join
    repeat (3) begin @(posedge clk); #1; end

    begin
      int bad;
      bad = 0;
      for (int j = 0; j < 1024; j++) if (dut_mem[j] !== ref_mem[j]) bad++;
      check("final_mem_diff_bytes", bad, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
